mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Performs loads and stores against the near-memory data port using a valid/ready request plus response handshake with variable latency.
- Stalls upstream stages until the access completes, then presents ALU result, load data, destination register and write enables for MEM/WB to capture.
- MEM/WB has no stall input, so this block emits bubbles (both write enables low) while it is busy.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ plus WAIT before the access is aborted. Counter width is clog2(TIMEOUT_CYCLES+1).
- ERR_DATA, 32'hDEAD_BEEF: value driven on lmd_o when an access aborts.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- alu_in  in  32  EX result; this is the byte address for memory operations
- store_data  in  32  rt value for stores
- reg_dst  in  5  destination register
- mem_read  in  1  load instruction
- mem_store  in  1  store instruction
- alu_write  in  1  ALU-result writeback requested
- size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- is_unsigned  in  1  zero-extend loads
- stall_o  out  1  hold EX/MEM and earlier stages
- req_valid  out  1  memory request valid
- req_ready  in  1  memory accepts request
- req_we  out  1  1 = write
- req_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- req_wdata  out  32  store data replicated per lane
- req_be  out  4  byte enables
- resp_valid  in  1  read data valid
- resp_rdata  in  32  read data
- alu_o  out  32  to MEM/WB ALU input
- lmd_o  out  32  to MEM/WB LMD input
- reg_dst_o  out  5  to MEM/WB
- mem_write_o  out  1  load-data writeback enable, to MEM/WB
- alu_write_o  out  1  ALU writeback enable, to MEM/WB
- err_o  out  1  one-cycle pulse on misalign or timeout

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset value is IDLE.
- Reset values: all registered state 0, lmd register 0, all outputs 0. Reset takes effect asynchronously, including in the middle of an operation: req_valid drops immediately and any later resp_valid is ignored.
- IDLE, no memory op:
  - stall_o=0.
  - alu_o, reg_dst_o and alu_write_o pass through combinationally from the inputs.
  - mem_write_o=0, lmd_o = lmd register.
- IDLE, mem_read or mem_store high:
  - stall_o=1 combinationally, and all writeback outputs are 0 (bubble).
  - On the clock edge, capture alu_in, store_data, reg_dst, op type, size and is_unsigned.
  - If aligned, go to REQ. Otherwise go to DONE with the misalign flag set.
  - If mem_store and mem_read are both high, the store wins.
- Alignment rules: half requires addr[0]=0; word requires addr[1:0]=0.
- REQ:
  - req_valid=1 with captured fields held stable until req_ready is sampled high.
  - On acceptance, a store goes to DONE and a load goes to WAIT.
  - stall_o=1, bubble on outputs.
- Request encoding:
  - Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
  - Write data: byte replicated x4, half replicated x2.
  - req_we=1 for stores.
- WAIT:
  - stall_o=1, bubble on outputs.
  - On resp_valid: shift resp_rdata right by 8*addr[1:0], extend from 8 or 16 bits (sign unless is_unsigned), store the result in the lmd register, go to DONE.
  - resp_valid seen in any state other than WAIT is ignored.
- Timeout:
  - The counter clears on entering REQ and increments every cycle spent in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES, go to DONE with the timeout flag set; lmd becomes ERR_DATA.
  - A handshake that completes in the same cycle as timeout expiry wins, and no error is raised.
- DONE (lasts exactly one cycle):
  - stall_o=0; alu_o and reg_dst_o come from the captured values.
  - Completed load: mem_write_o=1, alu_write_o=0. Completed store: both enables 0.
  - Error (misalign or timeout): both enables 0, err_o=1.
  - Next state is IDLE. The upstream stages advance on this edge.
- Throughput: one ALU op per cycle. A memory op occupies 1 + handshake cycles + 1 (DONE).

Test Plan:
- ALU op: alu_in=0x1234, alu_write=1, reg_dst=5 -> same cycle alu_o=0x1234, alu_write_o=1, stall_o=0, req_valid never asserted.
- Word load at 0x100, req_ready in cycle 2, resp_valid 3 cycles later with 0xCAFEF00D -> req_addr=0x100, req_be=1111, stall_o held through WAIT, then one DONE cycle with lmd_o=0xCAFEF00D, mem_write_o=1.
- Signed byte load at 0x203 with rdata=0x80FFFFFF -> lmd_o=0xFFFFFF80. Same access with is_unsigned=1 -> 0x00000080.
- Half store of 0xABCD1234 at 0x302 -> req_be=1100, req_wdata=0x12341234, req_we=1, DONE with both enables 0.
- Word load at 0x101 -> no req_valid, DONE with err_o=1, mem_write_o=0. Load with resp never arriving, TIMEOUT_CYCLES=8 -> err_o after 8 cycles, lmd_o=0xDEADBEEF.
- Reset asserted during WAIT, then resp_valid arrives -> immediate req_valid=0, stall_o=0, state IDLE, response ignored, lmd_o=0.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Near-memory data port: valid/ready request channel plus a read-response channel.
// The pipeline's MEM stage is the master; the memory side is the slave.
interface mem_access_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: performs loads/stores over the near-memory port and emits bubbles
// to MEM/WB while the access is in flight, since MEM/WB cannot be stalled.
module mem_access_stage #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         alu_in,
  input  logic [31:0]         store_data,
  input  logic [4:0]          reg_dst,
  input  logic                mem_read,
  input  logic                mem_store,
  input  logic                alu_write,
  input  logic [1:0]          size,
  input  logic                is_unsigned,
  output logic                stall_o,
  mem_access_stage_if.master  mem,
  output logic [31:0]         alu_o,
  output logic [31:0]         lmd_o,
  output logic [4:0]          reg_dst_o,
  output logic                mem_write_o,
  output logic                alu_write_o,
  output logic                err_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t          state, state_next;
  logic [31:0]     addr_q, data_q, lmd_q, lmd_next;
  logic [4:0]      rd_q;
  logic [1:0]      size_q;
  logic            store_q, uns_q, err_q, err_next;
  logic [CW-1:0]   cnt_q, cnt_next, cnt_inc;
  logic            is_op, aligned_in, expired, in_req;
  logic [31:0]     shifted, load_ext;
  logic [3:0]      be;
  logic [31:0]     wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      size_q  <= '0;
      store_q <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      lmd_q   <= '0;
    end else begin
      state <= state_next;
      cnt_q <= cnt_next;
      lmd_q <= lmd_next;
      err_q <= err_next;
      if (state == IDLE && is_op) begin
        addr_q  <= alu_in;
        data_q  <= store_data;
        rd_q    <= reg_dst;
        size_q  <= size;
        store_q <= mem_store;
        uns_q   <= is_unsigned;
      end
    end
  end

  // The timeout counter saturates so a late expiry in WAIT still fires after an
  // acceptance that landed exactly on the expiry cycle.
  always_comb begin
    is_op   = mem_read | mem_store;
    cnt_inc = (cnt_q == CW'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + 1'b1;
    expired = (cnt_q >= CW'(TIMEOUT_CYCLES - 1));
    case (size)
      2'b00:   aligned_in = 1'b1;
      2'b01:   aligned_in = ~alu_in[0];
      default: aligned_in = (alu_in[1:0] == 2'b00);
    endcase

    shifted = mem.resp_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase

    state_next = state;
    cnt_next   = cnt_q;
    lmd_next   = lmd_q;
    err_next   = err_q;
    case (state)
      IDLE: begin
        if (is_op) begin
          cnt_next = '0;
          if (aligned_in) begin
            state_next = REQ;
            err_next   = 1'b0;
          end else begin
            state_next = DONE;
            err_next   = 1'b1;
            lmd_next   = ERR_DATA;
          end
        end
      end
      REQ: begin
        cnt_next = cnt_inc;
        if (mem.req_ready) begin
          state_next = store_q ? DONE : WAIT;
        end else if (expired) begin
          state_next = DONE;
          err_next   = 1'b1;
          lmd_next   = ERR_DATA;
        end
      end
      WAIT: begin
        cnt_next = cnt_inc;
        if (mem.resp_valid) begin
          state_next = DONE;
          lmd_next   = load_ext;
        end else if (expired) begin
          state_next = DONE;
          err_next   = 1'b1;
          lmd_next   = ERR_DATA;
        end
      end
      default: begin
        state_next = IDLE;
        err_next   = 1'b0;
      end
    endcase
  end

  always_comb begin
    in_req = (state == REQ);
    case (size_q)
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wdata = {4{data_q[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << addr_q[1:0];
        wdata = {2{data_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = data_q;
      end
    endcase
    mem.req_valid = in_req;
    mem.req_we    = in_req & store_q;
    mem.req_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
    mem.req_be    = in_req ? be : '0;
    mem.req_wdata = in_req ? wdata : '0;
  end

  // Writeback outputs: pass-through for ALU ops, bubbles while busy, result in DONE.
  always_comb begin
    stall_o     = 1'b0;
    alu_o       = '0;
    reg_dst_o   = '0;
    alu_write_o = 1'b0;
    mem_write_o = 1'b0;
    err_o       = 1'b0;
    lmd_o       = lmd_q;
    case (state)
      IDLE: begin
        if (is_op) begin
          stall_o = 1'b1;
        end else begin
          alu_o       = alu_in;
          reg_dst_o   = reg_dst;
          alu_write_o = alu_write;
        end
      end
      REQ, WAIT: stall_o = 1'b1;
      default: begin
        alu_o       = addr_q;
        reg_dst_o   = rd_q;
        mem_write_o = ~store_q & ~err_q;
        err_o       = err_q;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: a transaction-level model predicts every
// cycle of each access from the bench-driven handshake timing.
module tb_mem_access_stage;
  localparam int          T   = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_in, store_data;
  logic [4:0]  reg_dst;
  logic        mem_read, mem_store, alu_write, is_unsigned;
  logic [1:0]  size;
  logic        stall_o, mem_write_o, alu_write_o, err_o;
  logic [31:0] alu_o, lmd_o;
  logic [4:0]  reg_dst_o;

  mem_access_stage_if mem();

  mem_access_stage #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERR)) dut (
    .clk(clk), .reset(reset), .alu_in(alu_in), .store_data(store_data),
    .reg_dst(reg_dst), .mem_read(mem_read), .mem_store(mem_store),
    .alu_write(alu_write), .size(size), .is_unsigned(is_unsigned),
    .stall_o(stall_o), .mem(mem), .alu_o(alu_o), .lmd_o(lmd_o),
    .reg_dst_o(reg_dst_o), .mem_write_o(mem_write_o),
    .alu_write_o(alu_write_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_miss = 0;
  bit          check_en = 1'b0;
  bit          exp_stall, exp_req_valid, exp_req_we, exp_mw, exp_aw, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_alu, model_lmd;
  logic [3:0]  exp_be;
  logic [4:0]  exp_rd;

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit modelAligned(logic [31:0] a, logic [1:0] sz);
    if (sz == 2'd0) return 1'b1;
    if (sz == 2'd1) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [3:0] modelBe(logic [31:0] a, logic [1:0] sz);
    logic [3:0] b = '0;
    int off = int'(a % 4);
    for (int i = 0; i < 4; i++)
      b[i] = (sz == 2'd0) ? (i == off) : (sz == 2'd1) ? (i == off || i == off + 1) : 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] modelWdata(logic [31:0] sd, logic [1:0] sz);
    if (sz == 2'd0) return (sd % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (sd % 65536) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] modelLoad(logic [31:0] rdata, logic [31:0] a,
                                            logic [1:0] sz, bit un);
    logic [31:0] sh = rdata >> (8 * (a % 4));
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = sh % 256;
      if (!un && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = sh % 65536;
      if (!un && v >= 32768) v = v - 65536;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("stall_o", 32'(stall_o), 32'(exp_stall));
      checkOutput("req_valid", 32'(mem.req_valid), 32'(exp_req_valid));
      if (exp_req_valid) begin
        checkOutput("req_we", 32'(mem.req_we), 32'(exp_req_we));
        checkOutput("req_addr", mem.req_addr, exp_addr);
        checkOutput("req_be", 32'(mem.req_be), 32'(exp_be));
        checkOutput("req_wdata", mem.req_wdata, exp_wdata);
      end
      checkOutput("mem_write_o", 32'(mem_write_o), 32'(exp_mw));
      checkOutput("alu_write_o", 32'(alu_write_o), 32'(exp_aw));
      checkOutput("err_o", 32'(err_o), 32'(exp_err));
      checkOutput("lmd_o", lmd_o, model_lmd);
      if (!exp_stall) begin
        checkOutput("alu_o", alu_o, exp_alu);
        checkOutput("reg_dst_o", 32'(reg_dst_o), 32'(exp_rd));
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(bit rd, bit st, logic [31:0] a, logic [31:0] sd,
                               logic [4:0] r, bit aw, logic [1:0] sz, bit un,
                               bit rdy, bit rv, logic [31:0] rdat);
    mem_read = rd;  mem_store = st;  alu_in = a;  store_data = sd;
    reg_dst = r;  alu_write = aw;  size = sz;  is_unsigned = un;
    mem.req_ready = rdy;  mem.resp_valid = rv;  mem.resp_rdata = rdat;
  endtask

  // Busy cycles scramble the pipeline inputs: only captured values may matter.
  task automatic applyNoise(bit rdy, bit rv, logic [31:0] rdat);
    applyStimulus(1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
                  1'($urandom), 2'($urandom), 1'($urandom), rdy, rv, rdat);
  endtask

  task automatic aluOp(logic [31:0] a, logic [4:0] r, bit aw);
    nextCycle();
    applyStimulus(1'b0, 1'b0, a, $urandom, r, aw, 2'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), $urandom);
    exp_stall = 0; exp_req_valid = 0; exp_alu = a; exp_rd = r;
    exp_aw = aw; exp_mw = 0; exp_err = 0;
  endtask

  task automatic memOp(bit rd, bit st, logic [31:0] a, logic [31:0] sd, logic [4:0] r,
                       logic [1:0] sz, bit un, int rdy_dly, int rsp_dly, bit never,
                       logic [31:0] rdat, output logic [31:0] done_lmd, output bit done_err);
    bit          is_store = st;
    bit          err = !modelAligned(a, sz);
    bit          finished = err;
    bit          in_req = 1'b1;
    bit          rdy, hit;
    int          n = 0, ridx = 0, widx = 0;
    logic [31:0] pend = model_lmd;
    nextCycle();
    applyStimulus(rd, st, a, sd, r, 1'($urandom), sz, un, 1'($urandom), 1'($urandom), $urandom);
    exp_stall = 1; exp_req_valid = 0; exp_mw = 0; exp_aw = 0; exp_err = 0;
    while (!finished) begin
      n++;
      nextCycle();
      exp_stall = 1; exp_mw = 0; exp_aw = 0; exp_err = 0;
      if (in_req) begin
        rdy = (ridx == rdy_dly);
        applyNoise(rdy, 1'($urandom), $urandom);
        exp_req_valid = 1; exp_req_we = is_store; exp_addr = a & ~32'd3;
        exp_be = modelBe(a, sz); exp_wdata = modelWdata(sd, sz);
        if (rdy) begin
          if (is_store) finished = 1; else in_req = 0;
        end else if (n >= T) begin
          finished = 1; err = 1;
        end
        ridx++;
      end else begin
        hit = !never && (widx == rsp_dly);
        applyNoise(1'($urandom), hit, hit ? rdat : $urandom);
        exp_req_valid = 0;
        if (hit) begin
          finished = 1; pend = modelLoad(rdat, a, sz, un);
        end else if (n >= T) begin
          finished = 1; err = 1;
        end
        widx++;
      end
    end
    nextCycle();
    applyNoise(1'($urandom), 1'($urandom), $urandom);
    if (err) model_lmd = ERR;
    else if (!is_store) model_lmd = pend;
    exp_stall = 0; exp_req_valid = 0; exp_alu = a; exp_rd = r;
    exp_mw = !is_store && !err; exp_aw = 0; exp_err = err;
    done_lmd = model_lmd;
    done_err = err;
  endtask

  initial begin
    logic [31:0] dl;
    bit          de;
    bit          rd, st;
    reset = 1'b1;
    model_lmd = '0;
    applyStimulus(0, 0, '0, '0, '0, 0, '0, 0, 0, 0, '0);
    #3;
    checkOutput("reset stall_o", 32'(stall_o), 32'd0);
    checkOutput("reset req_valid", 32'(mem.req_valid), 32'd0);
    checkOutput("reset lmd_o", lmd_o, 32'd0);
    checkOutput("reset err_o", 32'(err_o), 32'd0);
    checkOutput("reset mem_write_o", 32'(mem_write_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_en = 1'b1;

    aluOp(32'h1234, 5'd5, 1'b1);
    memOp(1, 0, 32'h100, '0, 5'd7, 2'd2, 0, 1, 2, 0, 32'hCAFE_F00D, dl, de);
    checkOutput("pin word load", dl, 32'hCAFE_F00D);
    memOp(1, 0, 32'h203, '0, 5'd8, 2'd0, 0, 0, 1, 0, 32'h80FF_FFFF, dl, de);
    checkOutput("pin signed byte", dl, 32'hFFFF_FF80);
    memOp(1, 0, 32'h203, '0, 5'd8, 2'd0, 1, 2, 0, 0, 32'h80FF_FFFF, dl, de);
    checkOutput("pin unsigned byte", dl, 32'h0000_0080);
    memOp(0, 1, 32'h302, 32'hABCD_1234, 5'd9, 2'd1, 0, 0, 0, 0, '0, dl, de);
    checkOutput("pin half be", 32'(modelBe(32'h302, 2'd1)), 32'h0000_000C);
    checkOutput("pin half wdata", modelWdata(32'hABCD_1234, 2'd1), 32'h1234_1234);
    memOp(1, 0, 32'h101, '0, 5'd3, 2'd2, 0, 0, 0, 0, '0, dl, de);
    checkOutput("pin misalign err", 32'(de), 32'd1);
    memOp(1, 0, 32'h400, '0, 5'd4, 2'd2, 0, 0, 0, 1, '0, dl, de);
    checkOutput("pin timeout err", 32'(de), 32'd1);
    checkOutput("pin timeout lmd", dl, 32'hDEAD_BEEF);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 4) begin
        aluOp($urandom, 5'($urandom), 1'($urandom));
      end else begin
        rd = 1'($urandom);
        st = rd ? 1'($urandom) : 1'b1;
        memOp(rd, st, $urandom, $urandom, 5'($urandom), 2'($urandom), 1'($urandom),
              $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 9) == 0,
              $urandom, dl, de);
      end
    end

    // Reset landing mid-WAIT must abort the load and swallow its late response.
    memOp(1, 0, 32'h500, '0, 5'd1, 2'd2, 0, 0, 0, 0, 32'h1111_2222, dl, de);
    nextCycle();
    applyStimulus(1, 0, 32'h600, '0, 5'd2, 0, 2'd2, 0, 0, 0, '0);
    exp_stall = 1; exp_req_valid = 0; exp_mw = 0; exp_aw = 0; exp_err = 0;
    nextCycle();
    applyStimulus(0, 0, '0, '0, '0, 0, '0, 0, 1, 0, '0);
    exp_req_valid = 1; exp_req_we = 0; exp_addr = 32'h600;
    exp_be = modelBe(32'h600, 2'd2); exp_wdata = '0;
    nextCycle();
    mem.req_ready = 0;
    exp_req_valid = 0;
    @(negedge clk);
    #1;
    check_en = 1'b0;
    reset = 1'b1;
    model_lmd = '0;
    #1;
    checkOutput("rst-wait req_valid", 32'(mem.req_valid), 32'd0);
    checkOutput("rst-wait stall_o", 32'(stall_o), 32'd0);
    checkOutput("rst-wait lmd_o", lmd_o, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem.resp_valid = 1'b1;
    mem.resp_rdata = 32'h5555_AAAA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("post-rst stall_o", 32'(stall_o), 32'd0);
      checkOutput("post-rst mem_write_o", 32'(mem_write_o), 32'd0);
      checkOutput("post-rst err_o", 32'(err_o), 32'd0);
      checkOutput("post-rst lmd_o", lmd_o, 32'd0);
      checkOutput("post-rst req_valid", 32'(mem.req_valid), 32'd0);
    end
    mem.resp_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
